// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_unit
//  Purpose  : Pipeline hazard detection. Selects operand forwarding sources
//             for the instruction in EX, tracks outstanding long-latency
//             writes in a per-register pending scoreboard, raises a stall for
//             load-use / RAW / WAW / capacity hazards, and counts stall cycles.
//  Ports    : clk_i, rstn_i              clock, async active-low reset
//             ex_rs_addr_i               EX source addresses (NUM_SRC x 5)
//             fwd_rd_addr_i/_write_rd_i/_data_valid_i   forwarding stages
//             id_rs_addr_i/_rs_used_i/_rd_addr_i/_write_rd_i/_long_lat_i/
//             id_issue_i                 decode-stage instruction
//             cmpl_valid_i/_rd_addr_i    long-latency write-back
//             cnt_clear_i                clears the stall counter
//             fwd_sel_o                  0 = regfile, k = stage k-1
//             stall_o, pending_cnt_o, stall_cycles_o, sb_err_o
//  Revision : 1.0  initial release
// ============================================================================
module hazard_unit #(
  parameter int NUM_SRC     = 2,
  parameter int NUM_FWD     = 2,
  parameter int MAX_PENDING = 4,
  parameter int SELW        = $clog2(NUM_FWD + 1),
  parameter int CNTW        = $clog2(MAX_PENDING + 1)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [NUM_SRC*5-1:0]    ex_rs_addr_i,
  input  logic [NUM_FWD*5-1:0]    fwd_rd_addr_i,
  input  logic [NUM_FWD-1:0]      fwd_write_rd_i,
  input  logic [NUM_FWD-1:0]      fwd_data_valid_i,
  input  logic [NUM_SRC*5-1:0]    id_rs_addr_i,
  input  logic [NUM_SRC-1:0]      id_rs_used_i,
  input  logic [4:0]              id_rd_addr_i,
  input  logic                    id_write_rd_i,
  input  logic                    id_long_lat_i,
  input  logic                    id_issue_i,
  input  logic                    cmpl_valid_i,
  input  logic [4:0]              cmpl_rd_addr_i,
  input  logic                    cnt_clear_i,
  output logic [NUM_SRC*SELW-1:0] fwd_sel_o,
  output logic                    stall_o,
  output logic [CNTW-1:0]         pending_cnt_o,
  output logic [31:0]             stall_cycles_o,
  output logic                    sb_err_o
);

  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(MAX_PENDING);

  logic [31:0]     pending_q, pending_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [31:0]     stall_cnt_q, stall_cnt_d;
  logic            err_q, err_d;

  logic            load_use;
  logic            raw_hit;
  logic            waw_hit;
  logic            cap_hit;
  logic            set_en;
  logic            clr_en;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  // --------------------------------------------------------------------------
  // Forwarding select. Stages are scanned from oldest to newest so the lowest
  // matching index (most recent result) overwrites any older match.
  // --------------------------------------------------------------------------
  always_comb begin
    fwd_sel_o = '0;
    load_use  = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      logic [SELW-1:0] sel;
      logic            win_valid;
      sel       = '0;
      win_valid = 1'b1;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_write_rd_i[k] && (fwd_rd_addr_i[k*5 +: 5] != 5'd0) &&
            (fwd_rd_addr_i[k*5 +: 5] == ex_rs_addr_i[s*5 +: 5])) begin
          sel       = SELW'(k + 1);
          win_valid = fwd_data_valid_i[k];
        end
      end
      fwd_sel_o[s*SELW +: SELW] = sel;
      // A winning stage whose data is not final (load in flight) cannot be
      // bypassed; an older valid match must not be used instead.
      if (!win_valid) begin
        load_use = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard hazards. pending_q[0] is held at zero so x0 never stalls.
  // --------------------------------------------------------------------------
  always_comb begin
    raw_hit = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) begin
      if (id_rs_used_i[s] && pending_q[id_rs_addr_i[s*5 +: 5]]) begin
        raw_hit = 1'b1;
      end
    end
  end

  assign waw_hit = id_write_rd_i && pending_q[id_rd_addr_i];
  assign cap_hit = id_long_lat_i && id_write_rd_i && (cnt_q == CNT_MAX);
  assign stall_o = load_use || raw_hit || waw_hit || cap_hit;

  assign set_en   = id_issue_i && !stall_o && id_long_lat_i && id_write_rd_i &&
                    (id_rd_addr_i != 5'd0);
  // The completion sees the registered scoreboard only; no same-cycle bypass.
  assign clr_en   = cmpl_valid_i && pending_q[cmpl_rd_addr_i];
  assign set_mask = set_en ? (32'd1 << id_rd_addr_i)   : 32'd0;
  assign clr_mask = clr_en ? (32'd1 << cmpl_rd_addr_i) : 32'd0;

  // --------------------------------------------------------------------------
  // Next state. Set is applied after clear so a same-register pair ends set,
  // and the count nets to zero.
  // --------------------------------------------------------------------------
  always_comb begin
    pending_d    = (pending_q & ~clr_mask) | set_mask;
    pending_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (set_en && !clr_en) begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end else if (clr_en && !set_en) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CNTW'(1);
      end
    end

    err_d = err_q || (cmpl_valid_i && !pending_q[cmpl_rd_addr_i]);

    stall_cnt_d = stall_cnt_q;
    if (cnt_clear_i) begin
      stall_cnt_d = 32'd0;
    end else if (stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pending_q   <= 32'd0;
      cnt_q       <= '0;
      stall_cnt_q <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign pending_cnt_o  = cnt_q;
  assign stall_cycles_o = stall_cnt_q;
  assign sb_err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_unit
//  Purpose  : Self-checking bench for hazard_unit. Each scenario task pushes
//             expected values to a queue as it drives stimulus and pops them
//             when the DUT output is sampled on the falling clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [9:0]  ex_rs_addr_i;
  logic [9:0]  fwd_rd_addr_i;
  logic [1:0]  fwd_write_rd_i;
  logic [1:0]  fwd_data_valid_i;
  logic [9:0]  id_rs_addr_i;
  logic [1:0]  id_rs_used_i;
  logic [4:0]  id_rd_addr_i;
  logic        id_write_rd_i;
  logic        id_long_lat_i;
  logic        id_issue_i;
  logic        cmpl_valid_i;
  logic [4:0]  cmpl_rd_addr_i;
  logic        cnt_clear_i;
  logic [3:0]  fwd_sel_o;
  logic        stall_o;
  logic [2:0]  pending_cnt_o;
  logic [31:0] stall_cycles_o;
  logic        sb_err_o;

  logic [31:0] exp_q[$];
  logic [31:0] e;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk_i = ~clk_i;

  hazard_unit #(.NUM_SRC(2), .NUM_FWD(2), .MAX_PENDING(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ex_rs_addr_i(ex_rs_addr_i), .fwd_rd_addr_i(fwd_rd_addr_i),
    .fwd_write_rd_i(fwd_write_rd_i), .fwd_data_valid_i(fwd_data_valid_i),
    .id_rs_addr_i(id_rs_addr_i), .id_rs_used_i(id_rs_used_i),
    .id_rd_addr_i(id_rd_addr_i), .id_write_rd_i(id_write_rd_i),
    .id_long_lat_i(id_long_lat_i), .id_issue_i(id_issue_i),
    .cmpl_valid_i(cmpl_valid_i), .cmpl_rd_addr_i(cmpl_rd_addr_i),
    .cnt_clear_i(cnt_clear_i), .fwd_sel_o(fwd_sel_o), .stall_o(stall_o),
    .pending_cnt_o(pending_cnt_o), .stall_cycles_o(stall_cycles_o),
    .sb_err_o(sb_err_o)
  );

  // Watchdog: the bench must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic idle_inputs();
    ex_rs_addr_i     = '0;
    fwd_rd_addr_i    = '0;
    fwd_write_rd_i   = '0;
    fwd_data_valid_i = '0;
    id_rs_addr_i     = '0;
    id_rs_used_i     = '0;
    id_rd_addr_i     = '0;
    id_write_rd_i    = 1'b0;
    id_long_lat_i    = 1'b0;
    id_issue_i       = 1'b0;
    cmpl_valid_i     = 1'b0;
    cmpl_rd_addr_i   = '0;
    cnt_clear_i      = 1'b0;
  endtask

  // Advance past the next rising edge; inputs change 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle_inputs();
    id_rd_addr_i  = rd;
    id_write_rd_i = 1'b1;
    id_long_lat_i = 1'b1;
    id_issue_i    = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn_i = 1'b0;
    repeat (2) @(posedge clk_i);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL reset_stall got=%0h exp=%0h", stall_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({28'd0, fwd_sel_o} !== e) begin failures++; $display("FAIL reset_fwd_sel got=%0h exp=%0h", fwd_sel_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL reset_pending got=%0h exp=%0h", pending_cnt_o, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cycles_o !== e) begin failures++; $display("FAIL reset_stall_cycles got=%0h exp=%0h", stall_cycles_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, sb_err_o} !== e) begin failures++; $display("FAIL reset_sb_err got=%0h exp=%0h", sb_err_o, e); end
    rstn_i = 1'b1;
    step();
  endtask

  task automatic test_priority_fwd();
    // Three patterns: both stages match, only stage1 matches, x0 never forwards.
    logic [9:0] rs_tab [3] = '{10'd3, 10'd3, 10'd0};
    logic [9:0] rd_tab [3] = '{{5'd3, 5'd3}, {5'd3, 5'd4}, {5'd0, 5'd0}};
    logic [3:0] sel_tab[3] = '{4'd1, 4'd2, 4'd0};
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      ex_rs_addr_i     = rs_tab[i];
      fwd_rd_addr_i    = rd_tab[i];
      fwd_write_rd_i   = 2'b11;
      fwd_data_valid_i = 2'b11;
      exp_q.push_back({28'd0, sel_tab[i]});
      exp_q.push_back(32'd0);
      @(negedge clk_i);
      e = exp_q.pop_front(); checks++;
      if ({28'd0, fwd_sel_o} !== e) begin failures++; $display("FAIL prio_fwd_sel[%0d] got=%0h exp=%0h", i, fwd_sel_o, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL prio_fwd_stall[%0d] got=%0h exp=%0h", i, stall_o, e); end
      step();
    end
  endtask

  task automatic test_load_use();
    // Stage0 pending load wins over a valid stage1: stall, sel[1]=1.
    // Then stage0 valid, stage1 not: newest wins, no stall.
    logic [1:0] vld_tab[2] = '{2'b10, 2'b01};
    logic [3:0] sel_tab[2] = '{4'b0100, 4'b0100};
    logic       stl_tab[2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      ex_rs_addr_i     = {5'd5, 5'd0};
      fwd_rd_addr_i    = {5'd5, 5'd5};
      fwd_write_rd_i   = 2'b11;
      fwd_data_valid_i = vld_tab[i];
      exp_q.push_back({31'd0, stl_tab[i]});
      exp_q.push_back({28'd0, sel_tab[i]});
      @(negedge clk_i);
      e = exp_q.pop_front(); checks++;
      if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL load_use_stall[%0d] got=%0h exp=%0h", i, stall_o, e); end
      e = exp_q.pop_front(); checks++;
      if ({28'd0, fwd_sel_o} !== e) begin failures++; $display("FAIL load_use_sel[%0d] got=%0h exp=%0h", i, fwd_sel_o, e); end
      step();
    end
  endtask

  task automatic test_raw_release();
    issue_long(5'd7);
    cnt_clear_i = 1'b1;
    exp_q.push_back(32'd0);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL raw_issue_stall got=%0h exp=%0h", stall_o, e); end
    step();
    idle_inputs();
    id_rs_addr_i = {5'd0, 5'd7};
    id_rs_used_i = 2'b01;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        cmpl_valid_i   = 1'b1;
        cmpl_rd_addr_i = 5'd7;
      end
      exp_q.push_back(32'd1);
      @(negedge clk_i);
      e = exp_q.pop_front(); checks++;
      if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL raw_stall_cyc%0d got=%0h exp=%0h", c, stall_o, e); end
      step();
    end
    cmpl_valid_i = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd3); exp_q.push_back(32'd0);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL raw_release_stall got=%0h exp=%0h", stall_o, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cycles_o !== e) begin failures++; $display("FAIL raw_stall_cycles got=%0h exp=%0h", stall_cycles_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL raw_pending got=%0h exp=%0h", pending_cnt_o, e); end
    step();
  endtask

  task automatic test_capacity();
    for (int r = 1; r <= 4; r++) begin
      issue_long(5'(r));
      step();
    end
    issue_long(5'd5);
    exp_q.push_back(32'd4); exp_q.push_back(32'd1);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL cap_pending got=%0h exp=%0h", pending_cnt_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL cap_stall got=%0h exp=%0h", stall_o, e); end
    step();
    cmpl_valid_i   = 1'b1;
    cmpl_rd_addr_i = 5'd1;
    exp_q.push_back(32'd4); exp_q.push_back(32'd1);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL cap_blocked_pending got=%0h exp=%0h", pending_cnt_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL cap_cmpl_cycle_stall got=%0h exp=%0h", stall_o, e); end
    step();
    cmpl_valid_i = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd3);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL cap_release_stall got=%0h exp=%0h", stall_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL cap_release_pending got=%0h exp=%0h", pending_cnt_o, e); end
    step();
    for (int r = 2; r <= 5; r++) begin
      idle_inputs();
      cmpl_valid_i   = 1'b1;
      cmpl_rd_addr_i = 5'(r);
      step();
    end
    idle_inputs();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL cap_drain_pending got=%0h exp=%0h", pending_cnt_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, sb_err_o} !== e) begin failures++; $display("FAIL cap_sb_err got=%0h exp=%0h", sb_err_o, e); end
    step();
  endtask

  task automatic test_same_reg();
    issue_long(5'd9);
    step();
    issue_long(5'd9);
    exp_q.push_back(32'd1);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL waw_stall got=%0h exp=%0h", stall_o, e); end
    step();
    issue_long(5'd10);
    exp_q.push_back(32'd1);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL waw_no_set_pending got=%0h exp=%0h", pending_cnt_o, e); end
    step();
    issue_long(5'd11);
    cmpl_valid_i   = 1'b1;
    cmpl_rd_addr_i = 5'd10;
    exp_q.push_back(32'd0);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL swap_stall got=%0h exp=%0h", stall_o, e); end
    step();
    idle_inputs();
    id_rs_addr_i = {5'd11, 5'd10};
    id_rs_used_i = 2'b01;
    exp_q.push_back(32'd2); exp_q.push_back(32'd0);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL swap_pending got=%0h exp=%0h", pending_cnt_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL swap_bit10_clear got=%0h exp=%0h", stall_o, e); end
    step();
    id_rs_used_i = 2'b10;
    exp_q.push_back(32'd1);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL swap_bit11_set got=%0h exp=%0h", stall_o, e); end
    step();
    idle_inputs();
    cmpl_valid_i   = 1'b1;
    cmpl_rd_addr_i = 5'd9;
    step();
    cmpl_rd_addr_i = 5'd11;
    step();
    idle_inputs();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL swap_drain_pending got=%0h exp=%0h", pending_cnt_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, sb_err_o} !== e) begin failures++; $display("FAIL swap_sb_err got=%0h exp=%0h", sb_err_o, e); end
    step();
  endtask

  task automatic test_reset_error();
    idle_inputs();
    cmpl_valid_i   = 1'b1;
    cmpl_rd_addr_i = 5'd12;
    step();
    issue_long(5'd13);
    exp_q.push_back(32'd1);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, sb_err_o} !== e) begin failures++; $display("FAIL err_sticky_set got=%0h exp=%0h", sb_err_o, e); end
    step();
    idle_inputs();
    id_rs_addr_i = {5'd0, 5'd13};
    id_rs_used_i = 2'b01;
    step();
    idle_inputs();
    exp_q.push_back(32'd1);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL err_pre_reset_pending got=%0h exp=%0h", pending_cnt_o, e); end
    // Asynchronous reset mid-cycle, away from any clock edge.
    #2;
    rstn_i = 1'b0;
    #1;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL rst_pending got=%0h exp=%0h", pending_cnt_o, e); end
    e = exp_q.pop_front(); checks++;
    if (stall_cycles_o !== e) begin failures++; $display("FAIL rst_stall_cycles got=%0h exp=%0h", stall_cycles_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, sb_err_o} !== e) begin failures++; $display("FAIL rst_sb_err got=%0h exp=%0h", sb_err_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({31'd0, stall_o} !== e) begin failures++; $display("FAIL rst_stall got=%0h exp=%0h", stall_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({28'd0, fwd_sel_o} !== e) begin failures++; $display("FAIL rst_fwd_sel got=%0h exp=%0h", fwd_sel_o, e); end
    @(negedge clk_i);
    rstn_i = 1'b1;
    step();
    // The discarded x13 entry completes: now an error.
    cmpl_valid_i   = 1'b1;
    cmpl_rd_addr_i = 5'd13;
    step();
    idle_inputs();
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, sb_err_o} !== e) begin failures++; $display("FAIL stale_cmpl_err got=%0h exp=%0h", sb_err_o, e); end
    e = exp_q.pop_front(); checks++;
    if ({29'd0, pending_cnt_o} !== e) begin failures++; $display("FAIL stale_cmpl_pending got=%0h exp=%0h", pending_cnt_o, e); end
    // Completion to x0 is always an error.
    rstn_i = 1'b0;
    #2;
    rstn_i = 1'b1;
    step();
    cmpl_valid_i   = 1'b1;
    cmpl_rd_addr_i = 5'd0;
    step();
    idle_inputs();
    exp_q.push_back(32'd1);
    @(negedge clk_i);
    e = exp_q.pop_front(); checks++;
    if ({31'd0, sb_err_o} !== e) begin failures++; $display("FAIL x0_cmpl_err got=%0h exp=%0h", sb_err_o, e); end
    step();
  endtask

  initial begin
    idle_inputs();
    rstn_i = 1'b1;
    #1;
    test_reset();
    test_priority_fwd();
    test_load_use();
    test_raw_release();
    test_capacity();
    test_same_reg();
    test_reset_error();
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
